// File: rtl/game_sequencer.sv
// Round/level sequencer for the symbol-counting game: paces symbol spawns,
// tallies hits and misses, and hands level advance to the level controller.
module game_sequencer #(
    parameter int          HITS_PER_LEVEL = 10,
    parameter int          MAX_MISSES     = 3,
    parameter int          INTRO_CYCLES   = 100000000,
    parameter int          SYM_BITS       = 4,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic                Clk100M,
    input  logic                Rst,
    input  logic                start,
    input  logic                hit,
    input  logic                miss,
    input  logic                newLevel,
    input  logic                victory,
    input  logic [3:0]          curLevel,
    input  logic [31:0]         symGenMax,
    output logic                incLevel,
    output logic                spawnSym,
    output logic [SYM_BITS-1:0] symCode,
    output logic [15:0]         score,
    output logic [3:0]          missCnt,
    output logic                playing,
    output logic                gameOver,
    output logic                won,
    output logic [3:0]          levelOut
);

    typedef enum logic [2:0] {
        IDLE, INTRO, PLAY, LVL_DONE, LVL_WAIT, WIN, LOSE
    } state_t;

    localparam logic [15:0] SEED_EFF    = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;
    localparam logic [31:0] INTRO_LAST  = 32'(INTRO_CYCLES - 1);
    localparam logic [15:0] HITS_TARGET = 16'(HITS_PER_LEVEL);
    localparam logic [3:0]  MISS_TARGET = 4'(MAX_MISSES);

    state_t      state_reg;
    logic [31:0] intro_cnt_reg;
    logic [31:0] spawn_timer_reg;
    logic [15:0] hit_cnt_reg;
    logic [15:0] lfsr_reg;

    logic [15:0] lfsr_next;
    logic [15:0] hit_cnt_next;
    logic [15:0] score_next;
    logic [3:0]  miss_cnt_next;
    logic [31:0] period_last;

    // Fibonacci LFSR, x^16+x^14+x^13+x^11+1, shifting toward the MSB
    assign lfsr_next[0] = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];
    generate
        for (genvar gi = 1; gi < 16; gi++) begin : g_lfsr_shift
            assign lfsr_next[gi] = lfsr_reg[gi-1];
        end
    endgenerate

    always_comb begin
        period_last   = (symGenMax == 32'd0) ? 32'd0 : symGenMax - 32'd1;
        hit_cnt_next  = hit_cnt_reg;
        score_next    = score;
        miss_cnt_next = missCnt;
        if (hit) begin
            hit_cnt_next = hit_cnt_reg + 16'd1;
            if (score != 16'hFFFF)
                score_next = score + 16'd1;
        end
        if (miss && missCnt != 4'hF)
            miss_cnt_next = missCnt + 4'd1;
    end

    always_ff @(posedge Clk100M) begin
        if (Rst) begin
            state_reg       <= IDLE;
            intro_cnt_reg   <= '0;
            spawn_timer_reg <= '0;
            hit_cnt_reg     <= '0;
            lfsr_reg        <= SEED_EFF;
            incLevel        <= 1'b0;
            spawnSym        <= 1'b0;
            symCode         <= '0;
            score           <= '0;
            missCnt         <= '0;
            playing         <= 1'b0;
            gameOver        <= 1'b0;
            won             <= 1'b0;
            levelOut        <= '0;
        end else begin
            levelOut <= curLevel;
            incLevel <= 1'b0;
            spawnSym <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg     <= INTRO;
                        intro_cnt_reg <= '0;
                    end
                end
                INTRO: begin
                    intro_cnt_reg <= intro_cnt_reg + 32'd1;
                    if (intro_cnt_reg == INTRO_LAST) begin
                        state_reg       <= PLAY;
                        spawn_timer_reg <= '0;
                        hit_cnt_reg     <= '0;
                        playing         <= 1'b1;
                    end
                end
                PLAY: begin
                    hit_cnt_reg <= hit_cnt_next;
                    score       <= score_next;
                    missCnt     <= miss_cnt_next;
                    // Leaving PLAY wins over a spawn that falls due on the same cycle
                    if (miss_cnt_next == MISS_TARGET) begin
                        state_reg       <= LOSE;
                        spawn_timer_reg <= '0;
                        playing         <= 1'b0;
                        gameOver        <= 1'b1;
                        won             <= 1'b0;
                    end else if (hit_cnt_next == HITS_TARGET) begin
                        state_reg       <= LVL_DONE;
                        spawn_timer_reg <= '0;
                        playing         <= 1'b0;
                    end else if (spawn_timer_reg >= period_last) begin
                        spawn_timer_reg <= '0;
                        spawnSym        <= 1'b1;
                        symCode         <= lfsr_reg[SYM_BITS-1:0];
                        lfsr_reg        <= lfsr_next;
                    end else begin
                        spawn_timer_reg <= spawn_timer_reg + 32'd1;
                    end
                end
                LVL_DONE: begin
                    incLevel  <= 1'b1;
                    state_reg <= LVL_WAIT;
                end
                LVL_WAIT: begin
                    if (victory) begin
                        state_reg <= WIN;
                        gameOver  <= 1'b1;
                        won       <= 1'b1;
                    end else if (newLevel) begin
                        state_reg     <= INTRO;
                        intro_cnt_reg <= '0;
                    end
                end
                WIN, LOSE: begin
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboarded bench for game_sequencer: predicted symbol codes are queued
// at reset and popped by a monitor on every spawn pulse.
module tb_game_sequencer;

    localparam int HPL = 2;
    localparam int MM  = 2;
    localparam int IC  = 4;
    localparam int SB  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        hit = 1'b0;
    logic        miss = 1'b0;
    logic        new_level = 1'b0;
    logic        victory = 1'b0;
    logic [3:0]  cur_level = 4'd1;
    logic [31:0] sym_gen_max = 32'd5;

    logic          inc_level;
    logic          spawn_sym;
    logic [SB-1:0] sym_code;
    logic [15:0]   score;
    logic [3:0]    miss_cnt;
    logic          playing;
    logic          game_over;
    logic          won;
    logic [3:0]    level_out;

    game_sequencer #(
        .HITS_PER_LEVEL(HPL), .MAX_MISSES(MM), .INTRO_CYCLES(IC),
        .SYM_BITS(SB), .LFSR_SEED(16'hACE1)
    ) dut (
        .Clk100M(clk), .Rst(rst), .start(start), .hit(hit), .miss(miss),
        .newLevel(new_level), .victory(victory), .curLevel(cur_level),
        .symGenMax(sym_gen_max), .incLevel(inc_level), .spawnSym(spawn_sym),
        .symCode(sym_code), .score(score), .missCnt(miss_cnt),
        .playing(playing), .gameOver(game_over), .won(won), .levelOut(level_out)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] model_lfsr;
    logic [SB-1:0] sym_q[$];

    task automatic refill();
        sym_q.delete();
        model_lfsr = 16'hACE1;
        for (int i = 0; i < 64; i++) begin
            sym_q.push_back(model_lfsr[SB-1:0]);
            model_lfsr = {model_lfsr[14:0],
                          model_lfsr[15] ^ model_lfsr[13] ^ model_lfsr[12] ^ model_lfsr[10]};
        end
    endtask

    int cyc = 0;
    int spawn_count = 0;
    int inc_count = 0;
    int last_spawn = 0;
    bit last_valid = 1'b0;
    int per_exp = 5;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            last_valid = 1'b0;
        end else begin
            if (inc_level) inc_count++;
            if (!playing) last_valid = 1'b0;
            if (spawn_sym) begin
                spawn_count++;
                check("sym_avail", 32'(sym_q.size() > 0), 1);
                if (sym_q.size() > 0) check("sym_code", 32'(sym_code), 32'(sym_q.pop_front()));
                if (last_valid && per_exp != 0) check("spawn_period", 32'(cyc - last_spawn), 32'(per_exp));
                last_spawn = cyc;
                last_valid = 1'b1;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_inc"},   32'(inc_level), 0);
        check({tag, "_spawn"}, 32'(spawn_sym), 0);
        check({tag, "_sym"},   32'(sym_code), 0);
        check({tag, "_score"}, 32'(score), 0);
        check({tag, "_miss"},  32'(miss_cnt), 0);
        check({tag, "_play"},  32'(playing), 0);
        check({tag, "_over"},  32'(game_over), 0);
        check({tag, "_won"},   32'(won), 0);
        check({tag, "_lvl"},   32'(level_out), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        check_reset_outputs("rst");
        rst = 1'b0;
        refill();
        inc_count = 0;
        spawn_count = 0;
    endtask

    task automatic go_play();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (IC) tick();
        check("play_enter", 32'(playing), 1);
    endtask

    int sc;

    initial begin
        // Reset, intro timing and spawn cadence
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (IC - 1) tick();
        check("intro_not_yet", 32'(playing), 0);
        tick();
        check("intro_done", 32'(playing), 1);
        check("level_out", 32'(level_out), 1);
        repeat (4) tick();
        check("spawn_not_yet", 32'(spawn_sym), 0);
        tick();
        check("first_spawn", 32'(spawn_sym), 1);
        repeat (11) tick();
        check("spawn_count3", 32'(spawn_count), 3);

        // Clear level, advance via newLevel, re-enter play
        hit = 1'b1; tick(); hit = 1'b0; tick();
        hit = 1'b1; tick(); hit = 1'b0;
        check("lvl_exit", 32'(playing), 0);
        check("inc_early", 32'(inc_level), 0);
        tick();
        check("inc_pulse", 32'(inc_level), 1);
        new_level = 1'b1;
        tick();
        new_level = 1'b0;
        check("inc_drop", 32'(inc_level), 0);
        repeat (IC - 1) tick();
        check("intro2_not_yet", 32'(playing), 0);
        tick();
        check("intro2_done", 32'(playing), 1);
        check("inc_once", 32'(inc_count), 1);
        check("score_l1", 32'(score), 2);
        check("miss_l1", 32'(miss_cnt), 0);

        // Two misses end the game; later inputs ignored
        miss = 1'b1; tick(); tick(); miss = 1'b0;
        check("lose_over", 32'(game_over), 1);
        check("lose_won", 32'(won), 0);
        check("lose_play", 32'(playing), 0);
        check("lose_miss", 32'(miss_cnt), 2);
        sc = spawn_count;
        start = 1'b1; hit = 1'b1;
        repeat (15) tick();
        start = 1'b0; hit = 1'b0;
        check("lose_nospawn", 32'(spawn_count), 32'(sc));
        check("lose_score", 32'(score), 2);
        check("lose_hold", 32'(game_over), 1);

        // Simultaneous hit and miss both counted; miss limit wins
        do_reset();
        go_play();
        hit = 1'b1; tick(); hit = 1'b0; tick();
        miss = 1'b1; tick(); miss = 1'b0; tick();
        check("hm_score1", 32'(score), 1);
        check("hm_miss1", 32'(miss_cnt), 1);
        check("hm_play", 32'(playing), 1);
        hit = 1'b1; miss = 1'b1; tick(); hit = 1'b0; miss = 1'b0;
        check("hm_score2", 32'(score), 2);
        check("hm_miss2", 32'(miss_cnt), 2);
        check("hm_over", 32'(game_over), 1);
        check("hm_won", 32'(won), 0);
        tick(); tick();
        check("hm_noinc", 32'(inc_count), 0);

        // Victory takes priority over newLevel
        do_reset();
        go_play();
        hit = 1'b1; tick(); tick(); hit = 1'b0;
        tick();
        check("win_inc", 32'(inc_level), 1);
        victory = 1'b1; new_level = 1'b1;
        tick();
        victory = 1'b0; new_level = 1'b0;
        check("win_over", 32'(game_over), 1);
        check("win_won", 32'(won), 1);
        repeat (IC + 2) tick();
        check("win_noplay", 32'(playing), 0);

        // Zero period spawns every cycle; reset mid-play
        do_reset();
        go_play();
        per_exp = 0;
        sym_gen_max = 32'd0;
        tick(); tick();
        for (int i = 0; i < 6; i++) begin
            check("p0_spawn", 32'(spawn_sym), 1);
            tick();
        end
        rst = 1'b1;
        tick();
        check_reset_outputs("midrst");
        rst = 1'b0;
        sym_gen_max = 32'd5;
        per_exp = 5;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
